cfo_packet_arbiter: RTL and testbench
=====================================

Name: cfo_packet_arbiter

Overview:
Arbitrates HB, DREQ and PREFETCH packet requests from the CFO emulation logic onto the single SERDES packet generator, one packet at a time. Latches each request type with its event window tag and grants by fixed priority (HB > DREQ > PREF). Enforces the generator's busy handshake, a minimum inter-packet gap and an HB protection window. Provides grant counters and error flags for diagnostics registers.

Parameters:
TAG_W, 48, event window tag width (`EVENT_TAG_BITS)
MIN_GAP, 8, idle serdesclk cycles enforced between generator busy falling and the next grant (1..255)
ACK_TIMEOUT, 64, max cycles waiting for gen_busy to rise after pkt_start (2..255)
CNT_W, 32, width of diagnostic grant counters

Ports:
serdesclk  in  1  150 MHz clock
serdesclk_resetn  in  1  reset
clear  in  1  sync pulse: clears counters, sticky flags and pending latches
hb_req  in  1  1-clk HB request pulse
hb_tag  in  TAG_W  HB tag, sampled with hb_req
dreq_req  in  1  1-clk DREQ request pulse
dreq_tag  in  TAG_W  DREQ tag
pref_req  in  1  1-clk PREFETCH request pulse
pref_tag  in  TAG_W  PREF tag
hb_guard  in  1  level: HB imminent, DREQ/PREF grants blocked
gen_busy  in  1  generator transmitting a packet
pkt_start  out  1  1-clk start to generator
pkt_type  out  4  1=HB, 2=DREQ, 3=PREF; held until next grant
pkt_tag  out  TAG_W  tag of granted packet; held until next grant
arb_idle  out  1  state IDLE and no pending requests
cnt_hb, cnt_dreq, cnt_pref  out  CNT_W each  granted packet counts
drop_flag  out  1  sticky: request arrived while same type already pending
timeout_flag  out  1  sticky: ACK_TIMEOUT expired

Behaviour:
- Reset: async, active-low, serdesclk_resetn, asynchronous, active-low; clock serdesclk. All outputs 0 on reset; arb_idle=1 one cycle after release. State IDLE, pending latches cleared.
- Pending latches: req pulse sets pend_x and captures tag_x. Request with pend_x already set: keep the old tag, discard the new one, set drop_flag. A request arriving in the same cycle its pending latch is granted is latched as new (no drop).
- FSM IDLE: select the highest-priority eligible pending. HB is always eligible. DREQ/PREF are eligible only when hb_guard=0. If an entry is selected -> ISSUE.
- ISSUE (1 cycle): pkt_start=1, pkt_type/pkt_tag updated, pend cleared, matching counter incremented -> WAIT_ACK. Latency from req pulse to pkt_start is 2 cycles when idle.
- WAIT_ACK: gen_busy=1 -> BUSY. After ACK_TIMEOUT cycles without busy: set timeout_flag -> GAP.
- BUSY: gen_busy=0 -> GAP.
- GAP: count MIN_GAP cycles -> IDLE. Pending requests still latch during GAP.
- hb_guard rising while DREQ/PREF pending: they stay pending and are granted after guard falls. hb_guard has no effect on a grant already issued.
- All three requests in one cycle: HB, DREQ, PREF are granted in successive arbitration rounds.
- Counters wrap modulo 2^CNT_W without a flag.
- clear: highest priority over all updates in that cycle. An in-flight FSM transaction continues to completion.
- gen_busy=1 while in IDLE: no grant until it is 0.

Decomposition:
- Shared package/header (tracker_params.vh): PKT_TYPE_HB=1, PKT_TYPE_DREQ=2, PKT_TYPE_PREF=3, EVENT_TAG_BITS, FSM state encodings.
- One sub-module, cfo_req_latch (pending bit + tag register + drop detect), instantiated three times. The FSM and counters stay in the top module.

Test Plan:
- Single DREQ with tag 0x5 and generator busy for 20 cycles: pkt_start 2 cycles after dreq_req, pkt_type=2, pkt_tag=0x5, cnt_dreq=1, next grant no earlier than 8 cycles after busy falls.
- hb_req, dreq_req and pref_req in the same cycle with tags 0xA/0xB/0xC: three grants in order of types 1,2,3 with matching tags; counters each =1.
- hb_guard=1 with DREQ pending for 100 cycles, then an HB request: HB granted during guard, DREQ granted only after guard=0.
- Two dreq_req pulses (tags 0x1, 0x2) while generator is busy: one DREQ with tag 0x1 granted, drop_flag=1, cnt_dreq=1.
- Generator never asserts busy: timeout_flag=1 after 64 cycles, FSM passes through GAP and then grants the next pending request.
- Assert reset during BUSY: all outputs 0, pending requests lost. After reset release, a new request is granted normally.

Source files
------------

// File: rtl/cfo_packet_arbiter_pkg.sv
// Shared constants for the CFO packet arbiter: packet type codes, source indices,
// FSM state encoding.
package cfo_packet_arbiter_pkg;

  localparam int EVENT_TAG_BITS = 48;
  localparam int NUM_SRC        = 3;

  // Source index doubles as arbitration priority: lower index wins.
  localparam int SRC_HB   = 0;
  localparam int SRC_DREQ = 1;
  localparam int SRC_PREF = 2;

  localparam logic [3:0] PKT_TYPE_HB   = 4'd1;
  localparam logic [3:0] PKT_TYPE_DREQ = 4'd2;
  localparam logic [3:0] PKT_TYPE_PREF = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_BUSY     = 3'd3,
    ST_GAP      = 3'd4
  } arb_state_e;

  function automatic logic [3:0] src_to_type(input logic [1:0] src);
    case (src)
      2'd0:    return PKT_TYPE_HB;
      2'd1:    return PKT_TYPE_DREQ;
      default: return PKT_TYPE_PREF;
    endcase
  endfunction

endpackage

// File: rtl/cfo_packet_arbiter_req_latch.sv
// One pending-request slot: pending bit, captured tag, and a drop pulse when a
// request hits an already-occupied slot.
module cfo_req_latch #(
  parameter int TAG_W = 48
) (
  input  logic             serdesclk,
  input  logic             serdesclk_resetn,
  input  logic             clear,
  input  logic             req,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             grant,
  output logic             pend,
  output logic [TAG_W-1:0] tag,
  output logic             drop
);

  logic             pend_q, pend_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // A request landing on the grant cycle refills the slot instead of dropping.
  always_comb begin
    pend_d = pend_q;
    tag_d  = tag_q;
    drop   = 1'b0;
    if (clear) begin
      pend_d = 1'b0;
    end else if (req && (!pend_q || grant)) begin
      pend_d = 1'b1;
      tag_d  = tag_in;
    end else if (req) begin
      drop = 1'b1;
    end else if (grant) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
    if (!serdesclk_resetn) begin
      pend_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tag_q  <= tag_d;
    end
  end

  assign pend = pend_q;
  assign tag  = tag_q;

endmodule

// File: rtl/cfo_packet_arbiter.sv
// Fixed-priority HB > DREQ > PREF arbiter feeding the SERDES packet generator,
// with busy handshake, ack timeout, inter-packet gap and HB guard window.
module cfo_packet_arbiter
  import cfo_packet_arbiter_pkg::*;
#(
  parameter int TAG_W       = EVENT_TAG_BITS,
  parameter int MIN_GAP     = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             serdesclk,
  input  logic             serdesclk_resetn,
  input  logic             clear,
  input  logic             hb_req,
  input  logic [TAG_W-1:0] hb_tag,
  input  logic             dreq_req,
  input  logic [TAG_W-1:0] dreq_tag,
  input  logic             pref_req,
  input  logic [TAG_W-1:0] pref_tag,
  input  logic             hb_guard,
  input  logic             gen_busy,
  output logic             pkt_start,
  output logic [3:0]       pkt_type,
  output logic [TAG_W-1:0] pkt_tag,
  output logic             arb_idle,
  output logic [CNT_W-1:0] cnt_hb,
  output logic [CNT_W-1:0] cnt_dreq,
  output logic [CNT_W-1:0] cnt_pref,
  output logic             drop_flag,
  output logic             timeout_flag
);

  logic [NUM_SRC-1:0]            req_vec, grant_vec, pend_vec, drop_vec, elig;
  logic [NUM_SRC-1:0][TAG_W-1:0] tag_in_vec, tag_vec;

  assign req_vec    = {pref_req, dreq_req, hb_req};
  assign tag_in_vec = {pref_tag, dreq_tag, hb_tag};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lat
    cfo_req_latch #(.TAG_W(TAG_W)) u_lat (
      .serdesclk        (serdesclk),
      .serdesclk_resetn (serdesclk_resetn),
      .clear            (clear),
      .req              (req_vec[g]),
      .tag_in           (tag_in_vec[g]),
      .grant            (grant_vec[g]),
      .pend             (pend_vec[g]),
      .tag              (tag_vec[g]),
      .drop             (drop_vec[g])
    );
  end

  arb_state_e                    state_q, state_d;
  logic [7:0]                    timer_q, timer_d;
  logic                          pkt_start_q, pkt_start_d;
  logic [3:0]                    pkt_type_q, pkt_type_d;
  logic [TAG_W-1:0]              pkt_tag_q, pkt_tag_d;
  logic                          arb_idle_q, arb_idle_d;
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                          drop_q, drop_d;
  logic                          timeout_q, timeout_d;
  logic                          sel_vld;
  logic [1:0]                    sel;

  // HB may always go; the guard only holds back DREQ/PREF.
  always_comb begin
    elig = pend_vec;
    if (hb_guard) elig[NUM_SRC-1:1] = '0;
    sel_vld = 1'b0;
    sel     = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_vld = 1'b1;
        sel     = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pkt_start_d = 1'b0;
    pkt_type_d  = pkt_type_q;
    pkt_tag_d   = pkt_tag_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    drop_d      = drop_q | (|drop_vec);
    grant_vec   = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld && !gen_busy && !clear) begin
          grant_vec[sel] = 1'b1;
          pkt_start_d    = 1'b1;
          pkt_type_d     = src_to_type(sel);
          pkt_tag_d      = tag_vec[sel];
          cnt_d[sel]     = cnt_q[sel] + CNT_W'(1);
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (gen_busy) begin
          state_d = ST_BUSY;
        end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = ST_GAP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_BUSY: begin
        if (!gen_busy) begin
          timer_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_q == 8'(MIN_GAP - 1)) state_d = ST_IDLE;
        else                            timer_d = timer_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      cnt_d     = '0;
      drop_d    = 1'b0;
      timeout_d = 1'b0;
    end
    arb_idle_d = (state_q == ST_IDLE) && !(|pend_vec);
  end

  always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
    if (!serdesclk_resetn) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pkt_start_q <= 1'b0;
      pkt_type_q  <= '0;
      pkt_tag_q   <= '0;
      arb_idle_q  <= 1'b0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pkt_start_q <= pkt_start_d;
      pkt_type_q  <= pkt_type_d;
      pkt_tag_q   <= pkt_tag_d;
      arb_idle_q  <= arb_idle_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pkt_start    = pkt_start_q;
  assign pkt_type     = pkt_type_q;
  assign pkt_tag      = pkt_tag_q;
  assign arb_idle     = arb_idle_q;
  assign cnt_hb       = cnt_q[SRC_HB];
  assign cnt_dreq     = cnt_q[SRC_DREQ];
  assign cnt_pref     = cnt_q[SRC_PREF];
  assign drop_flag    = drop_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_cfo_packet_arbiter.sv
// Bench for cfo_packet_arbiter: table of single-request vectors plus hand sequences,
// grants checked against a scoreboard of expected {type, tag}.
module tb_cfo_packet_arbiter;
  localparam int TAG_W   = 48;
  localparam int MIN_GAP = 8;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic             hb_req = 1'b0, dreq_req = 1'b0, pref_req = 1'b0;
  logic [TAG_W-1:0] hb_tag = '0, dreq_tag = '0, pref_tag = '0;
  logic             hb_guard = 1'b0;
  logic             gen_busy = 1'b0;
  logic             pkt_start, arb_idle, drop_flag, timeout_flag;
  logic [3:0]       pkt_type;
  logic [TAG_W-1:0] pkt_tag;
  logic [CNT_W-1:0] cnt_hb, cnt_dreq, cnt_pref;

  cfo_packet_arbiter dut (
    .serdesclk(clk), .serdesclk_resetn(rst_n), .clear(clear),
    .hb_req(hb_req), .hb_tag(hb_tag), .dreq_req(dreq_req), .dreq_tag(dreq_tag),
    .pref_req(pref_req), .pref_tag(pref_tag), .hb_guard(hb_guard), .gen_busy(gen_busy),
    .pkt_start(pkt_start), .pkt_type(pkt_type), .pkt_tag(pkt_tag), .arb_idle(arb_idle),
    .cnt_hb(cnt_hb), .cnt_dreq(cnt_dreq), .cnt_pref(cnt_pref),
    .drop_flag(drop_flag), .timeout_flag(timeout_flag)
  );

  always #3 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] typ; logic [TAG_W-1:0] tag; } exp_t;
  typedef struct { int src; logic [TAG_W-1:0] tag; int busy; logic [3:0] exp_type; } vec_t;

  exp_t sb[$];
  int   start_log[$];
  int   total = 0, bad = 0;
  int   starts = 0, last_start_cyc = 0, fall_cyc = -1000;
  int   busy_len = 20, gen_cnt = 0;
  bit   gen_en = 1'b1, gen_arm = 1'b0;
  int   exp_cnt[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Generator model: busy rises the cycle after pkt_start and stays for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !gen_en) begin
        gen_busy = 1'b0; gen_cnt = 0; gen_arm = 1'b0;
      end else if (gen_arm) begin
        gen_arm = 1'b0; gen_busy = 1'b1; gen_cnt = busy_len;
      end else if (gen_busy) begin
        gen_cnt--;
        if (gen_cnt == 0) begin gen_busy = 1'b0; fall_cyc = cyc; end
      end
      if (rst_n && gen_en && pkt_start) gen_arm = 1'b1;
    end
  end

  // Grant monitor: pops the scoreboard on every pkt_start.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pkt_start) begin
        starts++;
        last_start_cyc = cyc;
        start_log.push_back(cyc);
        chk("gap_after_busy", 64'(cyc - fall_cyc >= MIN_GAP + 2), 64'd1);
        if (sb.size() == 0) begin
          chk("unexpected_grant", 64'(pkt_type), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("pkt_type", 64'(pkt_type), 64'(e.typ));
          chk("pkt_tag", 64'(pkt_tag), 64'(e.tag));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pkt(input logic [3:0] t, input logic [TAG_W-1:0] tg);
    exp_t e;
    e.typ = t; e.tag = tg;
    sb.push_back(e);
  endtask

  task automatic send(input logic h, input logic d, input logic p,
                      input logic [TAG_W-1:0] th, input logic [TAG_W-1:0] td,
                      input logic [TAG_W-1:0] tp);
    hb_req = h; dreq_req = d; pref_req = p;
    hb_tag = th; dreq_tag = td; pref_tag = tp;
    tick(1);
    hb_req = 1'b0; dreq_req = 1'b0; pref_req = 1'b0;
  endtask

  task automatic send_src(input int src, input logic [TAG_W-1:0] tg);
    send(src == 0, src == 1, src == 2, tg, tg, tg);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cnt[2] = 0;
  endtask

  task automatic wait_start(input int target);
    int n = 0;
    while (starts < target && n < 500) begin tick(1); n++; end
    chk("wait_start_bound", 64'(starts >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(arb_idle && !gen_busy && sb.size() == 0) && n < 1000) begin tick(1); n++; end
    chk("wait_idle_bound", 64'(arb_idle && sb.size() == 0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_pkt_start"}, 64'(pkt_start), 64'd0);
    chk({tagname, "_pkt_type"}, 64'(pkt_type), 64'd0);
    chk({tagname, "_pkt_tag"}, 64'(pkt_tag), 64'd0);
    chk({tagname, "_arb_idle"}, 64'(arb_idle), 64'd0);
    chk({tagname, "_cnt_hb"}, 64'(cnt_hb), 64'd0);
    chk({tagname, "_cnt_dreq"}, 64'(cnt_dreq), 64'd0);
    chk({tagname, "_cnt_pref"}, 64'(cnt_pref), 64'd0);
    chk({tagname, "_drop"}, 64'(drop_flag), 64'd0);
    chk({tagname, "_timeout"}, 64'(timeout_flag), 64'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int   prev, r, s;
    vecs[0] = '{src: 1, tag: 48'h5,            busy: 20, exp_type: 4'd2};
    vecs[1] = '{src: 0, tag: 48'h123,          busy: 5,  exp_type: 4'd1};
    vecs[2] = '{src: 2, tag: 48'hFFFF_FFFF_FFFF, busy: 1, exp_type: 4'd3};
    vecs[3] = '{src: 0, tag: 48'h0,            busy: 3,  exp_type: 4'd1};
    exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cnt[2] = 0;

    #1 rst_n = 1'b0;
    #5 check_reset_outputs("reset");
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("idle_after_release", 64'(arb_idle), 64'd1);

    // Single-request vectors: latency, type/tag, counters.
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      busy_len = vecs[i].busy;
      expect_pkt(vecs[i].exp_type, vecs[i].tag);
      prev = starts;
      r = cyc;
      send_src(vecs[i].src, vecs[i].tag);
      wait_start(prev + 1);
      chk("req_to_start_latency", 64'(last_start_cyc - r), 64'd2);
      exp_cnt[vecs[i].src]++;
      chk("cnt_hb", 64'(cnt_hb), 64'(exp_cnt[0]));
      chk("cnt_dreq", 64'(cnt_dreq), 64'(exp_cnt[1]));
      chk("cnt_pref", 64'(cnt_pref), 64'(exp_cnt[2]));
    end
    wait_idle();

    // All three at once: strict priority order, back-to-back spacing busy+gap+handshake.
    do_clear();
    chk("clear_cnt_hb", 64'(cnt_hb), 64'd0);
    busy_len = 20;
    expect_pkt(4'd1, 48'hA); expect_pkt(4'd2, 48'hB); expect_pkt(4'd3, 48'hC);
    prev = starts;
    start_log.delete();
    send(1'b1, 1'b1, 1'b1, 48'hA, 48'hB, 48'hC);
    wait_start(prev + 3);
    if (start_log.size() >= 3) begin
      chk("b2b_spacing_1", 64'(start_log[1] - start_log[0]), 64'(busy_len + MIN_GAP + 3));
      chk("b2b_spacing_2", 64'(start_log[2] - start_log[1]), 64'(busy_len + MIN_GAP + 3));
    end else chk("b2b_starts", 64'(start_log.size()), 64'd3);
    wait_idle();
    chk("tri_cnt_hb", 64'(cnt_hb), 64'd1);
    chk("tri_cnt_dreq", 64'(cnt_dreq), 64'd1);
    chk("tri_cnt_pref", 64'(cnt_pref), 64'd1);

    // Second DREQ while one is pending: first tag kept, drop flagged.
    do_clear();
    expect_pkt(4'd1, 48'h9);
    prev = starts;
    send_src(0, 48'h9);
    wait_start(prev + 1);
    tick(3);
    expect_pkt(4'd2, 48'h1);
    send_src(1, 48'h1);
    tick(2);
    chk("no_drop_yet", 64'(drop_flag), 64'd0);
    send_src(1, 48'h2);
    chk("drop_flag", 64'(drop_flag), 64'd1);
    wait_idle();
    chk("drop_cnt_dreq", 64'(cnt_dreq), 64'd1);

    // Request landing on its own grant cycle is latched, not dropped.
    do_clear();
    chk("clear_drop", 64'(drop_flag), 64'd0);
    busy_len = 2;
    expect_pkt(4'd2, 48'h3); expect_pkt(4'd2, 48'h4);
    send_src(1, 48'h3);
    send_src(1, 48'h4);
    wait_idle();
    chk("grant_cycle_no_drop", 64'(drop_flag), 64'd0);
    chk("grant_cycle_cnt", 64'(cnt_dreq), 64'd2);

    // HB guard: DREQ held, HB passes, DREQ follows once the guard drops.
    do_clear();
    busy_len = 20;
    hb_guard = 1'b1;
    expect_pkt(4'd1, 48'h88); expect_pkt(4'd2, 48'h77);
    prev = starts;
    send_src(1, 48'h77);
    tick(100);
    chk("guard_blocks_dreq", 64'(starts - prev), 64'd0);
    chk("guard_not_idle", 64'(arb_idle), 64'd0);
    send_src(0, 48'h88);
    wait_start(prev + 1);
    tick(60);
    chk("guard_still_blocks", 64'(starts - prev), 64'd1);
    hb_guard = 1'b0;
    wait_start(prev + 2);
    wait_idle();

    // Generator never answers: timeout after ACK_TIMEOUT, then GAP, then next grant.
    gen_en = 1'b0;
    do_clear();
    expect_pkt(4'd2, 48'h21); expect_pkt(4'd3, 48'h22);
    prev = starts;
    send_src(1, 48'h21);
    wait_start(prev + 1);
    s = last_start_cyc;
    send_src(2, 48'h22);
    while (cyc < s + 64) tick(1);
    chk("timeout_not_early", 64'(timeout_flag), 64'd0);
    tick(1);
    chk("timeout_flag", 64'(timeout_flag), 64'd1);
    gen_en = 1'b1;
    wait_start(prev + 2);
    chk("grant_after_timeout", 64'(last_start_cyc - s), 64'd74);
    wait_idle();

    // Reset while the generator is busy: everything cleared, pending DREQ lost.
    busy_len = 20;
    expect_pkt(4'd1, 48'h55);
    prev = starts;
    send_src(0, 48'h55);
    wait_start(prev + 1);
    tick(4);
    send_src(1, 48'h66);
    rst_n = 1'b0;
    #1 check_reset_outputs("busy_reset");
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("busy_reset_idle", 64'(arb_idle), 64'd1);
    prev = starts;
    tick(20);
    chk("pending_lost", 64'(starts - prev), 64'd0);
    expect_pkt(4'd3, 48'h77);
    send_src(2, 48'h77);
    wait_start(prev + 1);
    wait_idle();
    chk("post_reset_cnt_pref", 64'(cnt_pref), 64'd1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
